// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between core fetch and load/store ports.
// Optional loader port and RUN/DRAIN/LOAD sequencing are compiled in with MEM_ARB_LOADER_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_RUN   | core IF/D ports arbitrated round-robin
//   ST_DRAIN | no grants; waiting for outstanding reads to return
//   ST_LOAD  | loader owns the memory; core held off
module mem_arbiter #(
   parameter int MEM_LAT = 1,
   parameter int AW      = 30
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
`ifdef MEM_ARB_LOADER_EN
   input  logic          ld_mode,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [31:0]   ld_rdata,
`endif
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata
);

   typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D, TAG_LD} tag_t;

   tag_t       tag_q [MEM_LAT];
   tag_t       tag_new;
   tag_t       tag_tail;
   logic       last_d;
   logic       core_en;
   logic [2:0] out_cnt;
   logic [2:0] cnt_nxt;
   logic       drained;

`ifdef MEM_ARB_LOADER_EN
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;
   state_t state;

   assign core_en = (state == ST_RUN);
`else
   assign core_en = 1'b1;
`endif

   // last_d set means D was granted last, so IF wins the next conflict
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (core_en) begin
         if (if_req && (!d_req || last_d))
            if_gnt = 1'b1;
         else if (d_req)
            d_gnt = 1'b1;
      end
   end

`ifdef MEM_ARB_LOADER_EN
   assign ld_gnt = (state == ST_LOAD) && ld_req;
`endif

   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      tag_new = TAG_NONE;
      if (if_gnt) begin
         m_en    = 1'b1;
         m_addr  = if_addr;
         tag_new = TAG_IF;
      end else if (d_gnt) begin
         m_en    = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         tag_new = d_we ? TAG_NONE : TAG_D;
      end
`ifdef MEM_ARB_LOADER_EN
      else if (ld_gnt) begin
         m_en    = 1'b1;
         m_we    = ld_we;
         m_addr  = ld_addr;
         m_wdata = ld_wdata;
         tag_new = ld_we ? TAG_NONE : TAG_LD;
      end
`endif
   end

   assign tag_tail  = tag_q[MEM_LAT-1];
   assign if_rvalid = (tag_tail == TAG_IF);
   assign d_rvalid  = (tag_tail == TAG_D);
   assign if_rdata  = m_rdata;
   assign d_rdata   = m_rdata;
`ifdef MEM_ARB_LOADER_EN
   assign ld_rvalid = (tag_tail == TAG_LD);
   assign ld_rdata  = m_rdata;
`endif

   // Count after this cycle: the tail response completes now, so it no longer holds off LOAD/RUN.
   assign cnt_nxt = out_cnt + 3'(tag_new != TAG_NONE) - 3'(tag_tail != TAG_NONE);
   assign drained = (cnt_nxt == 3'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d  <= 1'b1;
         out_cnt <= 3'd0;
         for (int i = 0; i < MEM_LAT; i++)
            tag_q[i] <= TAG_NONE;
      end else begin
         if (if_gnt)
            last_d <= 1'b0;
         else if (d_gnt)
            last_d <= 1'b1;
         out_cnt  <= cnt_nxt;
         tag_q[0] <= tag_new;
         for (int i = 1; i < MEM_LAT; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

`ifdef MEM_ARB_LOADER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:
               if (ld_mode)
                  state <= ST_DRAIN;
            ST_DRAIN:
               if (!ld_mode)
                  state <= ST_RUN;
               else if (drained)
                  state <= ST_LOAD;
            ST_LOAD:
               if (!ld_mode && drained)
                  state <= ST_RUN;
            default:
               state <= ST_RUN;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a at MEM_LAT=1, instance b at MEM_LAT=3.
// Loader sequencing is exercised only when MEM_ARB_LOADER_EN is defined.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        rst_a, rst_b;
   logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
   logic [29:0] a_if_addr, a_d_addr, a_m_addr;
   logic [31:0] a_if_rdata, a_d_rdata, a_d_wdata, a_m_wdata, a_m_rdata;
   logic        a_m_en, a_m_we;
   logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
   logic [29:0] b_if_addr, b_d_addr, b_m_addr;
   logic [31:0] b_if_rdata, b_d_rdata, b_d_wdata, b_m_wdata, b_m_rdata;
   logic        b_m_en, b_m_we;
`ifdef MEM_ARB_LOADER_EN
   logic        a_ld_mode, a_ld_req, a_ld_we, a_ld_gnt, a_ld_rvalid;
   logic [29:0] a_ld_addr;
   logic [31:0] a_ld_wdata, a_ld_rdata;
   logic        b_ld_mode, b_ld_req, b_ld_we, b_ld_gnt, b_ld_rvalid;
   logic [29:0] b_ld_addr;
   logic [31:0] b_ld_wdata, b_ld_rdata;
`endif

   mem_arbiter #(.MEM_LAT(1), .AW(30)) u_a (
      .clk(clk), .rst_n(rst_a),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
`ifdef MEM_ARB_LOADER_EN
      .ld_mode(a_ld_mode), .ld_req(a_ld_req), .ld_we(a_ld_we), .ld_addr(a_ld_addr),
      .ld_wdata(a_ld_wdata), .ld_gnt(a_ld_gnt), .ld_rvalid(a_ld_rvalid), .ld_rdata(a_ld_rdata),
`endif
      .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
   );

   mem_arbiter #(.MEM_LAT(3), .AW(30)) u_b (
      .clk(clk), .rst_n(rst_b),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
`ifdef MEM_ARB_LOADER_EN
      .ld_mode(b_ld_mode), .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr),
      .ld_wdata(b_ld_wdata), .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
`endif
      .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
   );

   // Memory models: word i resets to 0xA0000000 | i; read data appears MEM_LAT cycles after the access.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] b_pipe [3];

   always @(posedge clk) begin
      if (!rst_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA000_0000 | 32'(i);
      end else if (a_m_en) begin
         if (a_m_we) mem_a[a_m_addr[7:0]] <= a_m_wdata;
         else        a_m_rdata <= mem_a[a_m_addr[7:0]];
      end
   end

   always @(posedge clk) begin
      if (!rst_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA000_0000 | 32'(i);
      end else if (b_m_en && b_m_we) begin
         mem_b[b_m_addr[7:0]] <= b_m_wdata;
      end
      b_pipe[0] <= mem_b[b_m_addr[7:0]];
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign b_m_rdata = b_pipe[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
      b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
`ifdef MEM_ARB_LOADER_EN
      a_ld_mode = 0; a_ld_req = 0; a_ld_we = 0; a_ld_addr = '0; a_ld_wdata = '0;
      b_ld_mode = 0; b_ld_req = 0; b_ld_we = 0; b_ld_addr = '0; b_ld_wdata = '0;
`endif
      repeat (3) cyc();
      #1;
      check("rst_if_gnt", a_if_gnt, 0);
      check("rst_d_gnt", a_d_gnt, 0);
      check("rst_m_en", a_m_en, 0);
      check("rst_m_we", a_m_we, 0);
      check("rst_m_addr", a_m_addr, 0);
      check("rst_m_wdata", a_m_wdata, 0);
      check("rst_if_rvalid", a_if_rvalid, 0);
      check("rst_d_rvalid", a_d_rvalid, 0);
      rst_a = 1'b1; rst_b = 1'b1;

      // lone fetch, latency 1
      cyc(); a_if_req = 1; a_if_addr = 30'h10; #1;
      check("if_alone_gnt", a_if_gnt, 1);
      check("if_alone_m_en", a_m_en, 1);
      check("if_alone_m_we", a_m_we, 0);
      check("if_alone_m_addr", a_m_addr, 30'h10);
      check("if_alone_d_gnt", a_d_gnt, 0);
      cyc(); a_if_req = 0; a_d_req = 1; a_d_addr = 30'h11; #1;
      check("if_alone_rvalid", a_if_rvalid, 1);
      check("if_alone_rdata", a_if_rdata, 32'hA000_0010);
      check("if_alone_no_d_rvalid", a_d_rvalid, 0);
      check("d_alone_gnt", a_d_gnt, 1);
      cyc(); a_d_req = 0; #1;
      check("d_alone_rvalid", a_d_rvalid, 1);
      check("d_alone_rdata", a_d_rdata, 32'hA000_0011);
      check("d_alone_no_if_rvalid", a_if_rvalid, 0);
      check("idle_m_en", a_m_en, 0);

      // continuous contention alternates IF, D, IF, D, ...
      for (int k = 0; k < 6; k++) begin
         cyc();
         a_if_req = 1; a_if_addr = 30'h30; a_d_req = 1; a_d_we = 0; a_d_addr = 30'h40;
         #1;
         check($sformatf("cont_if_gnt%0d", k), a_if_gnt, (k % 2) == 0);
         check($sformatf("cont_d_gnt%0d", k), a_d_gnt, (k % 2) == 1);
         check($sformatf("cont_m_addr%0d", k), a_m_addr, (k % 2) == 0 ? 30'h30 : 30'h40);
         if (k > 0) begin
            check($sformatf("cont_if_rv%0d", k), a_if_rvalid, ((k - 1) % 2) == 0);
            check($sformatf("cont_d_rv%0d", k), a_d_rvalid, ((k - 1) % 2) == 1);
            check($sformatf("cont_rdata%0d", k), a_if_rdata,
                  ((k - 1) % 2) == 0 ? 32'hA000_0030 : 32'hA000_0040);
         end
      end
      cyc(); a_if_req = 0; a_d_req = 0; #1;
      check("cont_last_d_rv", a_d_rvalid, 1);
      check("cont_last_if_rv", a_if_rvalid, 0);
      check("cont_last_rdata", a_d_rdata, 32'hA000_0040);

      // write then read-back of the same address
      cyc(); a_d_req = 1; a_d_we = 1; a_d_addr = 30'h20; a_d_wdata = 32'hDEAD_BEEF; #1;
      check("wr_gnt", a_d_gnt, 1);
      check("wr_m_we", a_m_we, 1);
      check("wr_m_addr", a_m_addr, 30'h20);
      check("wr_m_wdata", a_m_wdata, 32'hDEAD_BEEF);
      cyc(); a_d_we = 0; a_d_wdata = '0; #1;
      check("rd_gnt", a_d_gnt, 1);
      check("rd_m_we", a_m_we, 0);
      check("wr_no_rvalid", a_d_rvalid, 0);
      cyc(); a_d_req = 0; #1;
      check("rd_rvalid", a_d_rvalid, 1);
      check("rd_rdata", a_d_rdata, 32'hDEAD_BEEF);

      // latency 3
      cyc(); b_if_req = 1; b_if_addr = 30'h05; #1;
      check("l3_gnt", b_if_gnt, 1);
      for (int j = 1; j <= 3; j++) begin
         cyc(); b_if_req = 0; #1;
         check($sformatf("l3_rvalid%0d", j), b_if_rvalid, j == 3);
      end
      check("l3_rdata", b_if_rdata, 32'hA000_0005);

      // reset pulse with two reads in flight
      cyc(); b_if_req = 1; b_if_addr = 30'h01; #1;
      check("rp_if_gnt", b_if_gnt, 1);
      cyc(); b_if_req = 0; b_d_req = 1; b_d_addr = 30'h02; #1;
      check("rp_d_gnt", b_d_gnt, 1);
      cyc(); b_d_req = 0; rst_b = 1'b0; #1;
      check("rp_if_rv_in_rst", b_if_rvalid, 0);
      cyc(); rst_b = 1'b1;
      for (int j = 0; j < 5; j++) begin
         cyc(); #1;
         check($sformatf("rp_if_rv%0d", j), b_if_rvalid, 0);
         check($sformatf("rp_d_rv%0d", j), b_d_rvalid, 0);
      end
      cyc(); b_if_req = 1; b_if_addr = 30'h07; #1;
      check("rp_after_gnt", b_if_gnt, 1);
      for (int j = 1; j <= 3; j++) begin
         cyc(); b_if_req = 0; #1;
         check($sformatf("rp_after_rv%0d", j), b_if_rvalid, j == 3);
      end
      check("rp_after_rdata", b_if_rdata, 32'hA000_0007);

`ifdef MEM_ARB_LOADER_EN
      // loader takeover with two reads outstanding
      cyc(); b_if_req = 1; b_if_addr = 30'h01; #1;
      check("ld_c0_if_gnt", b_if_gnt, 1);
      cyc(); b_if_req = 0; b_d_req = 1; b_d_addr = 30'h02; #1;
      check("ld_c1_d_gnt", b_d_gnt, 1);
      cyc(); b_d_req = 0; b_ld_mode = 1; #1;
      check("ld_c2_ld_gnt", b_ld_gnt, 0);
      cyc();
      b_if_req = 1; b_if_addr = 30'h03;
      b_ld_req = 1; b_ld_we = 1; b_ld_addr = 30'h0; b_ld_wdata = 32'h0000_0013;
      #1;
      check("ld_c3_if_gnt", b_if_gnt, 0);
      check("ld_c3_ld_gnt", b_ld_gnt, 0);
      check("ld_c3_if_rv", b_if_rvalid, 1);
      cyc(); #1;
      check("ld_c4_if_gnt", b_if_gnt, 0);
      check("ld_c4_ld_gnt", b_ld_gnt, 0);
      check("ld_c4_d_rv", b_d_rvalid, 1);
      cyc(); #1;
      check("ld_c5_ld_gnt", b_ld_gnt, 1);
      check("ld_c5_if_gnt", b_if_gnt, 0);
      check("ld_c5_m_we", b_m_we, 1);
      check("ld_c5_m_addr", b_m_addr, 30'h0);
      check("ld_c5_m_wdata", b_m_wdata, 32'h0000_0013);
      cyc(); b_ld_we = 0; b_ld_wdata = '0; #1;
      check("ld_c6_ld_gnt", b_ld_gnt, 1);
      check("ld_c6_m_we", b_m_we, 0);
      cyc(); b_ld_req = 0; #1;
      check("ld_c7_if_gnt", b_if_gnt, 0);
      check("ld_c7_ld_rv", b_ld_rvalid, 0);
      cyc(); #1;
      check("ld_c8_if_gnt", b_if_gnt, 0);
      cyc(); #1;
      check("ld_c9_ld_rv", b_ld_rvalid, 1);
      check("ld_c9_ld_rdata", b_ld_rdata, 32'h0000_0013);
      check("ld_c9_if_gnt", b_if_gnt, 0);
      cyc(); b_ld_mode = 0; #1;
      check("ld_c10_if_gnt", b_if_gnt, 0);
      cyc(); #1;
      check("ld_c11_if_gnt", b_if_gnt, 1);
      check("ld_c11_m_addr", b_m_addr, 30'h03);
      cyc(); b_if_req = 0;
`endif

      repeat (5) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
